// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iteration controller and state register for the iterative AES core
module aes_round_ctrl #(
  parameter int NUM_ROUNDS = 10,
  parameter int ROUND_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               d_tk,
  input  logic [127:0]       aes_in,
  input  logic               clear,
  output logic [127:0]       state_q,
  output logic [ROUND_W-1:0] round_num,
  output logic               final_round,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_data
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;
  localparam logic [ROUND_W-1:0] LAST = ROUND_W'(NUM_ROUNDS);
  fsm_e fsm_q, fsm_d;
  logic [127:0] state_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic last;
  assign last = round_q == LAST;
  assign round_num = round_q;
  // state, block and round-index registers; reset drops any block in flight
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fsm_q <= IDLE;
      state_q <= '0;
      round_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      state_q <= state_d;
      round_q <= round_d;
    end
  // next state: clear wins, IDLE loads raw input, ROUND captures round logic, DONE waits for consumer
  always_comb begin
    fsm_d = fsm_q;
    state_d = state_q;
    round_d = round_q;
    if (clear) begin
      fsm_d = IDLE;
      state_d = '0;
      round_d = '0;
    end else begin
      case (fsm_q)
        IDLE: if (in_valid) begin
          fsm_d = ROUND;
          state_d = aes_in;
          round_d = '0;
        end
        ROUND: begin
          state_d = aes_in;
          round_d = last ? '0 : round_q + 1'b1;
          fsm_d = last ? DONE : ROUND;
        end
        DONE: fsm_d = out_ready ? IDLE : DONE;
        default: fsm_d = IDLE;
      endcase
    end
  end
  // outputs decoded purely from registered state
  always_comb begin
    in_ready = fsm_q == IDLE;
    d_tk = fsm_q != IDLE;
    busy = fsm_q != IDLE;
    out_valid = fsm_q == DONE;
    final_round = (fsm_q == ROUND) && last;
    out_data = (fsm_q == DONE) ? state_q : '0;
  end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: scoreboard bench with a behavioural round-logic environment and FIPS-197 model
module tb_aes_round_ctrl;
  localparam int N = 10;
  logic clk = 0, rst = 1, in_valid = 0, clear = 0, out_ready = 1;
  logic in_ready, d_tk, final_round, busy, out_valid;
  logic [127:0] aes_in, state_q, out_data, blk = '0;
  logic [3:0] round_num;
  logic aes_mode = 0, rnd_ready = 0, active = 0;
  time acc_t = 0;
  int errs = 0, checks = 0;
  logic [127:0] sb [$];
  logic [7:0] sbox [256];
  logic [127:0] rk [11];

  aes_round_ctrl #(.NUM_ROUNDS(N), .ROUND_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .d_tk(d_tk),
    .aes_in(aes_in), .clear(clear), .state_q(state_q), .round_num(round_num),
    .final_round(final_round), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = xt(a);
    end
    return p;
  endfunction

  function automatic logic [127:0] aes_rnd(input logic [127:0] s, input logic [3:0] r, input logic fin);
    logic [7:0] a [16];
    logic [7:0] b [16];
    logic [127:0] o;
    if (r > 4'(N)) return '0;
    if (r == 0) return s ^ rk[0];
    for (int i = 0; i < 16; i++) a[i] = sbox[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int j = 0; j < 4; j++) b[j+4*c] = a[j+4*((c+j)%4)];
    for (int c = 0; c < 4; c++)
      o[127-32*c -: 32] = fin ? {b[4*c], b[4*c+1], b[4*c+2], b[4*c+3]} :
        {gm(b[4*c], 8'h02) ^ gm(b[4*c+1], 8'h03) ^ b[4*c+2] ^ b[4*c+3],
         b[4*c] ^ gm(b[4*c+1], 8'h02) ^ gm(b[4*c+2], 8'h03) ^ b[4*c+3],
         b[4*c] ^ b[4*c+1] ^ gm(b[4*c+2], 8'h02) ^ gm(b[4*c+3], 8'h03),
         gm(b[4*c], 8'h03) ^ b[4*c+1] ^ b[4*c+2] ^ gm(b[4*c+3], 8'h02)};
    return o ^ rk[r];
  endfunction

  task automatic init_tables();
    logic [7:0] inv, rc;
    logic [31:0] w [44];
    logic [31:0] t;
    logic [127:0] key;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++) if (x != 0 && gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    key = 128'h000102030405060708090a0b0c0d0e0f;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= N; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // external round logic: +1 counter model or a real AES round
  always_comb aes_in = !d_tk ? blk : aes_mode ? aes_rnd(state_q, round_num, final_round) : state_q + 128'd1;

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic chk_reset();
    chk("rst_state_q", state_q, 0);
    chk("rst_round_num", round_num, 0);
    chk("rst_d_tk", d_tk, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_final_round", final_round, 0);
    chk("rst_out_data", out_data, 0);
  endtask

  task automatic send(input logic [127:0] b, input logic [127:0] e);
    int n;
    n = 0;
    blk = b;
    in_valid = 1;
    while (!in_ready && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("send_accept", in_ready, 1);
    if (in_ready) begin
      @(posedge clk);
      acc_t = $time;
      sb.push_back(e);
      active = 1;
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_idle", busy, 0);
  endtask

  // timing model: round k is applied k cycles after acceptance, output appears after N+1 cycles
  always @(negedge clk) begin
    int k;
    if (active && !rst) begin
      k = int'(($time - acc_t - 5) / 10);
      if (k <= N) begin
        chk("round_num", round_num, k[3:0]);
        chk("final_round", final_round, k == N);
        chk("busy_round", busy, 1);
        chk("in_ready_round", in_ready, 0);
        chk("out_valid_early", out_valid, 0);
      end else begin
        chk("latency_out_valid", out_valid, 1);
        active = 0;
      end
    end
  end

  // scoreboard monitor: every presented output must match the oldest expected block
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_out: got %h expected none at %0t", out_data, $time);
      end else begin
        chk("out_data", out_data, sb[0]);
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  always @(posedge clk) if (rnd_ready) begin
    #1;
    out_ready = $urandom_range(0, 2) != 0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    time t1;
    logic [127:0] b;
    int n;
    init_tables();
    #1;
    chk_reset();
    @(posedge clk);
    #1;
    rst = 0;
    send(128'h0, 128'd11);
    in_valid = 0;
    drain();
    out_ready = 0;
    send(128'h0, 128'd11);
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      blk = 128'h777;
      @(posedge clk);
      #1;
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_out_data", out_data, 128'd11);
      chk("stall_state_q", state_q, 128'd11);
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk);
    #1;
    chk("handshake_drop", out_valid, 0);
    chk("handshake_idle", in_ready, 1);
    send(128'h100, 128'h10b);
    t1 = acc_t;
    send(128'h200, 128'h20b);
    chk("b2b_spacing", 128'(acc_t - t1), 128'((N + 3) * 10));
    in_valid = 0;
    drain();
    send(128'h0, 128'd11);
    in_valid = 0;
    repeat (5) @(posedge clk);
    #2;
    chk("pre_reset_round", round_num, 5);
    active = 0;
    sb.delete();
    rst = 1;
    #1;
    chk_reset();
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    send(128'h5, 128'h10);
    in_valid = 0;
    drain();
    send(128'h300, 128'h30b);
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_clear_round", round_num, 3);
    active = 0;
    sb.delete();
    clear = 1;
    in_valid = 1;
    blk = 128'h400;
    @(posedge clk);
    #1;
    clear = 0;
    chk("clear_busy", busy, 0);
    chk("clear_in_ready", in_ready, 1);
    chk("clear_round", round_num, 0);
    chk("clear_state_q", state_q, 0);
    chk("clear_out_valid", out_valid, 0);
    send(128'h400, 128'h40b);
    in_valid = 0;
    drain();
    aes_mode = 1;
    send(128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    in_valid = 0;
    drain();
    aes_mode = 0;
    rnd_ready = 1;
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      b = {$urandom, $urandom, $urandom, $urandom};
      send(b, b + 128'(N + 1));
      in_valid = 0;
    end
    drain();
    rnd_ready = 0;
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
